// File: rtl/pc_sequencer.sv
// Program-counter sequencer: tracks the fetch address, raises a one-cycle flush after
// taken jumps, and counts retired instructions. Optional macro: PC_HALT_DETECT_EN (jump-to-self halt).
module pc_sequencer #(
  parameter int                    ADDR_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    CNT_WIDTH    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_jump,
  input  logic [ADDR_WIDTH-1:0] i_target,
  input  logic                  i_instr_valid,
  input  logic                  i_stall,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic                  o_fetch_req,
  output logic                  o_flush,
  output logic [CNT_WIDTH-1:0]  o_icount,
  output logic                  o_halted
);

`ifdef PC_HALT_DETECT_EN
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} state_t;
`endif

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_next_pc;
  logic [CNT_WIDTH-1:0]  r_icount;
  logic [CNT_WIDTH-1:0]  w_next_icount;
  logic                  r_fetch_req;
  logic                  r_flush;
  logic                  r_halted;
  logic                  w_retire;
  logic                  w_halt_next;

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_retire     = 1'b0;
    case (r_state)
      S_BOOT: w_next_state = S_RUN;
      S_RUN: begin
        // stall dominates; a missing instruction just waits on memory
        if (!i_stall && i_instr_valid) begin
          w_retire = 1'b1;
          if (i_jump) begin
            w_next_pc = i_target;
`ifdef PC_HALT_DETECT_EN
            w_next_state = (i_target == r_pc) ? S_HALT : S_FLUSH;
`else
            w_next_state = S_FLUSH;
`endif
          end else begin
            w_next_pc = r_pc + 1'b1;
          end
        end
      end
      S_FLUSH: if (!i_stall) w_next_state = S_RUN;
`ifdef PC_HALT_DETECT_EN
      S_HALT: w_next_state = S_HALT;
`endif
      default: w_next_state = S_BOOT;
    endcase
  end

  assign w_next_icount = (w_retire && (r_icount != '1)) ? r_icount + 1'b1 : r_icount;

`ifdef PC_HALT_DETECT_EN
  assign w_halt_next = (w_next_state == S_HALT);
`else
  assign w_halt_next = 1'b0;
`endif

  // outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_BOOT;
      r_pc        <= RESET_VECTOR;
      r_icount    <= '0;
      r_fetch_req <= 1'b0;
      r_flush     <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_pc        <= w_next_pc;
      r_icount    <= w_next_icount;
      r_fetch_req <= (w_next_state == S_RUN) || (w_next_state == S_FLUSH);
      r_flush     <= (w_next_state == S_FLUSH);
      r_halted    <= w_halt_next;
    end
  end

  assign o_pc        = r_pc;
  assign o_fetch_req = r_fetch_req;
  assign o_flush     = r_flush;
  assign o_icount    = r_icount;
  assign o_halted    = r_halted;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage directly downstream of the jump-condition unit.
- Consumes the condition unit's single-bit jump decision plus the decoded jump target.
- Drives the instruction-fetch address, a one-cycle pipeline flush after taken jumps, and a retired-instruction counter.
- Sits between the ALU/condition path and instruction memory in the CPU datapath.

Parameters:
- ADDR_WIDTH, 8, width of the program counter and jump target.
- RESET_VECTOR, 0, PC value loaded on reset.
- CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_jump  input  1  jump decision from the condition unit for the current instruction.
- i_target  input  ADDR_WIDTH  jump destination for the current instruction.
- i_instr_valid  input  1  instruction at o_pc is present and decoded this cycle.
- i_stall  input  1  downstream hold; freezes PC and counter.
- o_pc  output  ADDR_WIDTH  current fetch address.
- o_fetch_req  output  1  request fetch at o_pc.
- o_flush  output  1  discard the instruction currently in decode.
- o_icount  output  CNT_WIDTH  retired-instruction count, saturating.
- o_halted  output  1  core halted (optional feature only; tied 0 otherwise).

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high. i_rst has priority over every other input.
- Reset values: o_pc=RESET_VECTOR, state=BOOT, o_fetch_req=0, o_flush=0, o_icount=0, o_halted=0.
- All outputs are registered.
- States: BOOT, RUN, FLUSH, HALT (HALT exists only with the optional feature).
- BOOT:
  - Lasts exactly one cycle, then moves to RUN.
  - o_fetch_req rises in the first RUN cycle.
  - i_instr_valid, i_jump and i_stall are ignored.
- RUN, o_fetch_req=1. Priority order:
  - i_stall=1: o_pc and o_icount hold; i_jump is ignored.
  - else i_instr_valid=0: o_pc holds (waiting on memory); no retire.
  - else i_jump=1: o_pc<=i_target, o_icount increments, next state FLUSH.
  - else: o_pc<=o_pc+1 modulo 2^ADDR_WIDTH, o_icount increments.
- Wrap-around: o_pc=all-ones increments to 0 with no flag.
- FLUSH:
  - o_flush=1 and o_fetch_req=1 for exactly one non-stalled cycle.
  - i_instr_valid and i_jump are ignored; o_pc holds the target.
  - Next state RUN.
  - If i_stall=1, the block stays in FLUSH with o_flush held high.
- Latency: a taken jump is visible on o_pc one cycle after the qualifying edge. The first target instruction can retire two cycles after the jump.
- o_icount saturates at all-ones and never wraps.
- Reset mid-FLUSH or mid-stall returns to the reset values on the next edge.

Optional Feature:
- Macro: PC_HALT_DETECT_EN.
- Defined:
  - A qualifying taken jump (RUN, no stall, i_instr_valid=1, i_jump=1) with i_target==o_pc enters HALT. This is the jump-to-self idiom.
  - o_icount still increments for that jump.
  - In HALT: o_halted=1, o_fetch_req=0, o_flush=0, o_pc and o_icount frozen.
  - Only i_rst exits HALT.
- Not defined: no HALT state, o_halted tied 0, and jump-to-self behaves as a normal taken jump through FLUSH.

Test Plan:
- Reset then 4 valid non-jump cycles (ADDR_WIDTH=8, RESET_VECTOR=0x10) -> BOOT cycle with o_fetch_req=0, then o_pc 0x10,0x11,0x12,0x13,0x14; o_icount=4.
- At o_pc=0x22: i_jump=1, i_target=0x80, valid -> next cycle o_pc=0x80, o_flush=1 for exactly one cycle, o_icount+1; with i_stall=1 during that cycle, o_flush stays 1 until the stall drops.
- i_stall=1 together with i_jump=1, i_target=0x05 at o_pc=0x30 -> o_pc stays 0x30, no flush, o_icount unchanged.
- Run to o_pc=0xFF, valid, no jump -> o_pc=0x00; with CNT_WIDTH=4, 20 retirements -> o_icount=0xF.
- PC_HALT_DETECT_EN: at o_pc=0x40, i_jump=1, i_target=0x40 -> o_halted=1, o_fetch_req=0, o_pc=0x40 held for 10 cycles; i_rst -> o_pc=RESET_VECTOR, o_halted=0. Without the macro, the same stimulus -> FLUSH, o_flush=1, o_pc=0x40, o_halted=0.
- Assert i_rst during FLUSH with o_icount=7 -> next edge o_pc=RESET_VECTOR, o_icount=0, o_flush=0, state BOOT.
